pfpu32_f2i_rnd: RTL and testbench
=================================

# pfpu32_f2i_rnd

Second and third pipeline stages of the pfpu32 float-to-integer conversion path. The block consumes the stage-1 output bundle `f2i_*`: aligned 24-bit mantissa, shift amounts, sign, overflow hint and sNaN flag. It performs the final alignment shift with guard and sticky capture, then applies OR1K rounding. It produces a saturated 32-bit two's-complement integer plus inexact and invalid flags for the FPU result mux and FPCSR update logic.

## Interface
Parameters: none.

- `clk`  in  1  core clock
- `rst_n`  in  1  reset, asynchronous, active-low; one clock domain
- `flush_i`  in  1  flush pipe; clears valid state
- `adv_i`  in  1  advance pipe; all stage registers load only when high
- `rmode_i`  in  2  rounding mode: 0 nearest-even, 1 toward zero, 2 toward +inf, 3 toward -inf
- `f2i_rdy_i`  in  1  stage-1 result valid
- `f2i_sign_i`  in  1  sign; already forced to 0 for NaN
- `f2i_int24_i`  in  24  mantissa including hidden bit
- `f2i_shr_i`  in  5  right shift, 0..31
- `f2i_shl_i`  in  4  left shift, 0..15
- `f2i_ovf_i`  in  1  stage-1 overflow
- `f2i_snan_i`  in  1  operand was sNaN
- `f2i_rnd_rdy_o`  out  1  result valid
- `f2i_int32_o`  out  32  integer result
- `f2i_ix_o`  out  1  inexact
- `f2i_inv_o`  out  1  invalid (overflow or NaN)
- `f2i_snan_o`  out  1  sNaN passthrough

## Operation
**Stage A (shift), registered on `adv_i`:**
- If `shl != 0`: `mag32 = {8'b0,int24} << shl`, truncated to 32 bits. Guard = 0, sticky = 0.
- Else: `mag32 = int24 >> shr`. Guard = `int24[shr-1]` (0 when shr=0). Sticky = OR of `int24[shr-2:0]` (0 when shr<2).
- When shr ≥ 25: mag = 0, guard = 0, sticky = `|int24`. When shr = 24: guard = `int24[23]`.
- Sign, ovf, snan and rmode are carried along with the data.

**Stage B (round/saturate), registered on `adv_i`:**
- `inc` by rounding mode:
  - RNE: `g & (s | mag[0])`
  - RTZ: 0
  - RUP: `~sign & (g|s)`
  - RDN: `sign & (g|s)`
- `mag33 = mag32 + inc`.
- `rovf` = (`~sign` & `mag33 > 0x7FFFFFFF`) | (`sign` & `mag33 > 0x80000000`).
- If `ovf | rovf`: int32 = sign ? `0x80000000` : `0x7FFFFFFF`, `inv` = 1, `ix` = 0.
- Else: int32 = sign ? `-mag33[31:0]` : `mag33[31:0]`, `inv` = 0, `ix` = `g|s`.
- NaN inputs arrive with ovf=1 and sign=0, so they produce `0x7FFFFFFF` with `inv` = 1. `snan_o` follows its input.
- -0.0 and underflowing inputs produce 0. Those underflowing inputs are inexact unless the mantissa is zero.

## Timing
- Latency: exactly 2 `adv_i`-high cycles from `f2i_rdy_i` to `f2i_rnd_rdy_o`. Throughput is 1 per advancing cycle.
- `adv_i` low: every register holds, including valid bits. Outputs stay stable.
- Valid regs priority: reset > `flush_i` > `adv_i`.
  - `flush_i` clears both stage valids in the same edge, regardless of `adv_i`.
  - Data regs are not cleared on flush.
- Reset (async assert, sync deassert handled externally): all outputs and internal registers go to 0.
- Reset mid-operation discards in-flight results. The first valid output after reset is the second advancing cycle after the first `f2i_rdy_i`.
- `f2i_rnd_rdy_o` is a level, not a pulse. It stays high while `adv_i` is low.
- Data outputs are meaningful only when `f2i_rnd_rdy_o` = 1.

## Structure
- `pfpu32_pkg` holds:
  - rounding mode constants `RM_NEAREST`, `RM_ZERO`, `RM_PLUSINF`, `RM_MININF`
  - `INT32_MAX`, `INT32_MIN`
- Sub-module `pfpu32_f2i_align`: combinational shifter producing mag32, guard and sticky. It is instantiated once for stage A.
- Stage registers and rounding logic live in the top module. Target size is about 200 lines.

## Test plan
- 1.5: int24=`0xC00000`, shr=23, RNE → `0x00000002`, ix=1, inv=0. Same operand with RTZ → `0x00000001`.
- 2.5: int24=`0xA00000`, shr=22, RNE → `0x00000002`, ix=1. -1.5 with RDN → `0xFFFFFFFE`; with RTZ → `0xFFFFFFFF`.
- -2^31: sign=1, int24=`0x800000`, shl=8, ovf=0 → `0x80000000`, inv=0, ix=0. +2^31 with ovf=1 → `0x7FFFFFFF`, inv=1.
- NaN: sign=0, ovf=1, snan=1 → `0x7FFFFFFF`, inv=1, snan_o=1. 1e-10 (shr=31, int24 nonzero) with RUP → `0x00000001`, ix=1.
- Back-to-back stream of 4 operands with `adv_i` toggled low for 3 cycles mid-stream → results are in order, outputs are frozen during the stall, and none are lost or duplicated.
- `flush_i` with 2 operands in flight, and `rst_n` pulsed low mid-stream → `f2i_rnd_rdy_o` = 0 next cycle and all outputs 0 after reset. The next operand emerges after 2 advances.

Source files
------------

// File: rtl/pfpu32_pkg.sv
// Shared constants for the pfpu32 float-to-integer path: rounding mode
// encodings and the saturation limits of a signed 32-bit integer.
package pfpu32_pkg;

  localparam logic [1:0] RM_NEAREST = 2'd0;
  localparam logic [1:0] RM_ZERO    = 2'd1;
  localparam logic [1:0] RM_PLUSINF = 2'd2;
  localparam logic [1:0] RM_MININF  = 2'd3;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

endpackage

// File: rtl/pfpu32_f2i_align.sv
// Final alignment shifter for float-to-integer conversion: produces the
// integer magnitude plus the guard and sticky bits lost to a right shift.
module pfpu32_f2i_align (
  input  logic [23:0] int24,
  input  logic [4:0]  shr,
  input  logic [3:0]  shl,
  output logic [31:0] mag32,
  output logic        guard,
  output logic        sticky
);

  // Upper half is the shifted mantissa, lower half the bits shifted out.
  logic [47:0] ext;

  // NOTE: every output gets a default before the branches so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    ext    = {int24, 24'd0} >> shr;
    mag32  = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    if (shl != 4'd0) begin
      mag32 = {8'd0, int24} << shl;
    end else if (shr >= 5'd25) begin
      sticky = |int24;
    end else begin
      mag32  = {8'd0, ext[47:24]};
      guard  = ext[23];
      sticky = |ext[22:0];
    end
  end

endmodule

// File: rtl/pfpu32_f2i_rnd.sv
// Float-to-integer stages 2 and 3: final alignment (stage A) followed by
// OR1K rounding and saturation to a signed 32-bit integer (stage B).
module pfpu32_f2i_rnd
  import pfpu32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        adv_i,
  input  logic [1:0]  rmode_i,
  input  logic        f2i_rdy_i,
  input  logic        f2i_sign_i,
  input  logic [23:0] f2i_int24_i,
  input  logic [4:0]  f2i_shr_i,
  input  logic [3:0]  f2i_shl_i,
  input  logic        f2i_ovf_i,
  input  logic        f2i_snan_i,
  output logic        f2i_rnd_rdy_o,
  output logic [31:0] f2i_int32_o,
  output logic        f2i_ix_o,
  output logic        f2i_inv_o,
  output logic        f2i_snan_o
);

  logic [31:0] al_mag;
  logic        al_guard;
  logic        al_sticky;

  pfpu32_f2i_align u_align (
    .int24  (f2i_int24_i),
    .shr    (f2i_shr_i),
    .shl    (f2i_shl_i),
    .mag32  (al_mag),
    .guard  (al_guard),
    .sticky (al_sticky)
  );

  // Stage A registers
  logic        a_vld;
  logic [31:0] a_mag;
  logic        a_guard;
  logic        a_sticky;
  logic        a_sign;
  logic        a_ovf;
  logic        a_snan;
  logic [1:0]  a_rmode;

  // Valid bits: flush wins over advance and ignores adv_i.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld         <= 1'b0;
      f2i_rnd_rdy_o <= 1'b0;
    end else if (flush_i) begin
      a_vld         <= 1'b0;
      f2i_rnd_rdy_o <= 1'b0;
    end else if (adv_i) begin
      a_vld         <= f2i_rdy_i;
      f2i_rnd_rdy_o <= a_vld;
    end
  end

  // NOTE: data registers are reset but deliberately not cleared on flush;
  // valid bits alone qualify them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mag    <= '0;
      a_guard  <= 1'b0;
      a_sticky <= 1'b0;
      a_sign   <= 1'b0;
      a_ovf    <= 1'b0;
      a_snan   <= 1'b0;
      a_rmode  <= RM_NEAREST;
    end else if (adv_i) begin
      a_mag    <= al_mag;
      a_guard  <= al_guard;
      a_sticky <= al_sticky;
      a_sign   <= f2i_sign_i;
      a_ovf    <= f2i_ovf_i;
      a_snan   <= f2i_snan_i;
      a_rmode  <= rmode_i;
    end
  end

  // Stage B combinational rounding and saturation
  logic        inc;
  logic [32:0] mag33;
  logic        rovf;
  logic [31:0] res_int32;
  logic        res_ix;
  logic        res_inv;

  always_comb begin
    inc = 1'b0;
    unique case (a_rmode)
      RM_NEAREST: inc = a_guard & (a_sticky | a_mag[0]);
      RM_ZERO:    inc = 1'b0;
      RM_PLUSINF: inc = ~a_sign & (a_guard | a_sticky);
      RM_MININF:  inc = a_sign & (a_guard | a_sticky);
      default:    inc = 1'b0;
    endcase

    mag33 = {1'b0, a_mag} + {32'd0, inc};
    rovf  = (~a_sign & (mag33 > {1'b0, INT32_MAX})) |
            ( a_sign & (mag33 > {1'b0, INT32_MIN}));

    res_int32 = '0;
    res_ix    = 1'b0;
    res_inv   = 1'b0;
    if (a_ovf | rovf) begin
      res_int32 = a_sign ? INT32_MIN : INT32_MAX;
      res_inv   = 1'b1;
    end else begin
      // Negating 0x80000000 wraps to itself, which is exactly INT32_MIN.
      res_int32 = a_sign ? (~mag33[31:0] + 32'd1) : mag33[31:0];
      res_ix    = a_guard | a_sticky;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f2i_int32_o <= '0;
      f2i_ix_o    <= 1'b0;
      f2i_inv_o   <= 1'b0;
      f2i_snan_o  <= 1'b0;
    end else if (adv_i) begin
      f2i_int32_o <= res_int32;
      f2i_ix_o    <= res_ix;
      f2i_inv_o   <= res_inv;
      f2i_snan_o  <= a_snan;
    end
  end

endmodule

// File: tb/tb_pfpu32_f2i_rnd.sv
// Directed self-checking bench for pfpu32_f2i_rnd: rounding modes,
// saturation, NaN, underflow, stall, flush and reset behaviour.
module tb_pfpu32_f2i_rnd;
  import pfpu32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        adv_i;
  logic [1:0]  rmode_i;
  logic        f2i_rdy_i;
  logic        f2i_sign_i;
  logic [23:0] f2i_int24_i;
  logic [4:0]  f2i_shr_i;
  logic [3:0]  f2i_shl_i;
  logic        f2i_ovf_i;
  logic        f2i_snan_i;
  logic        f2i_rnd_rdy_o;
  logic [31:0] f2i_int32_o;
  logic        f2i_ix_o;
  logic        f2i_inv_o;
  logic        f2i_snan_o;

  int n_tests = 0;
  int n_fail  = 0;

  pfpu32_f2i_rnd dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .adv_i         (adv_i),
    .rmode_i       (rmode_i),
    .f2i_rdy_i     (f2i_rdy_i),
    .f2i_sign_i    (f2i_sign_i),
    .f2i_int24_i   (f2i_int24_i),
    .f2i_shr_i     (f2i_shr_i),
    .f2i_shl_i     (f2i_shl_i),
    .f2i_ovf_i     (f2i_ovf_i),
    .f2i_snan_i    (f2i_snan_i),
    .f2i_rnd_rdy_o (f2i_rnd_rdy_o),
    .f2i_int32_o   (f2i_int32_o),
    .f2i_ix_o      (f2i_ix_o),
    .f2i_inv_o     (f2i_inv_o),
    .f2i_snan_o    (f2i_snan_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit so sampling is away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic sign, input logic [23:0] int24, input logic [4:0] shr,
                        input logic [3:0] shl, input logic ovf, input logic snan,
                        input logic [1:0] rm);
    f2i_sign_i  = sign;
    f2i_int24_i = int24;
    f2i_shr_i   = shr;
    f2i_shl_i   = shl;
    f2i_ovf_i   = ovf;
    f2i_snan_i  = snan;
    rmode_i     = rm;
  endtask

  // Issue one operand and advance twice; the result is then on the outputs.
  task automatic run_op(input logic sign, input logic [23:0] int24, input logic [4:0] shr,
                        input logic [3:0] shl, input logic ovf, input logic snan,
                        input logic [1:0] rm);
    set_op(sign, int24, shr, shl, ovf, snan, rm);
    f2i_rdy_i = 1'b1;
    adv_i     = 1'b1;
    tick();
    f2i_rdy_i = 1'b0;
    tick();
  endtask

  task automatic expect_res(input string tag, input logic [31:0] val, input logic ix,
                            input logic inv, input logic snan);
    check({tag, ".rdy"},  {31'd0, f2i_rnd_rdy_o}, 32'd1);
    check({tag, ".int"},  f2i_int32_o, val);
    check({tag, ".ix"},   {31'd0, f2i_ix_o},   {31'd0, ix});
    check({tag, ".inv"},  {31'd0, f2i_inv_o},  {31'd0, inv});
    check({tag, ".snan"}, {31'd0, f2i_snan_o}, {31'd0, snan});
  endtask

  initial begin
    rst_n     = 1'b0;
    flush_i   = 1'b0;
    adv_i     = 1'b0;
    f2i_rdy_i = 1'b0;
    set_op(1'b0, 24'd0, 5'd0, 4'd0, 1'b0, 1'b0, RM_NEAREST);
    #12;
    check("reset.rdy", {31'd0, f2i_rnd_rdy_o}, 32'd0);
    check("reset.int", f2i_int32_o, 32'd0);
    rst_n = 1'b1;
    tick();

    // Rounding of halves and signed values
    run_op(1'b0, 24'hC00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_NEAREST);
    expect_res("p1_5_rne", 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, 24'hC00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_ZERO);
    expect_res("p1_5_rtz", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, 24'hA00000, 5'd22, 4'd0, 1'b0, 1'b0, RM_NEAREST);
    expect_res("p2_5_rne", 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    run_op(1'b1, 24'hC00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_MININF);
    expect_res("n1_5_rdn", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    run_op(1'b1, 24'hC00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_ZERO);
    expect_res("n1_5_rtz", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, 24'hC00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_MININF);
    expect_res("p1_5_rdn", 32'h0000_0001, 1'b1, 1'b0, 1'b0);

    // Saturation and NaN
    run_op(1'b1, 24'h800000, 5'd0, 4'd8, 1'b0, 1'b0, RM_NEAREST);
    expect_res("n2p31", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 24'h800000, 5'd0, 4'd8, 1'b1, 1'b0, RM_NEAREST);
    expect_res("p2p31_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op(1'b0, 24'hFFFFFF, 5'd0, 4'd8, 1'b0, 1'b0, RM_NEAREST);
    expect_res("shl_rovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op(1'b0, 24'hC00000, 5'd0, 4'd0, 1'b1, 1'b1, RM_NEAREST);
    expect_res("snan", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);

    // Underflow, exact and shift boundaries
    run_op(1'b0, 24'hABCDEF, 5'd31, 4'd0, 1'b0, 1'b0, RM_PLUSINF);
    expect_res("tiny_rup", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, 24'hABCDEF, 5'd31, 4'd0, 1'b0, 1'b0, RM_NEAREST);
    expect_res("tiny_rne", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run_op(1'b1, 24'h000000, 5'd31, 4'd0, 1'b0, 1'b0, RM_MININF);
    expect_res("neg_zero", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 24'h800000, 5'd24, 4'd0, 1'b0, 1'b0, RM_NEAREST);
    expect_res("half_rne", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, 24'h800000, 5'd24, 4'd0, 1'b0, 1'b0, RM_PLUSINF);
    expect_res("half_rup", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, 24'h123456, 5'd0, 4'd0, 1'b0, 1'b0, RM_NEAREST);
    expect_res("shr0", 32'h0012_3456, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 24'h800003, 5'd23, 4'd0, 1'b0, 1'b0, RM_PLUSINF);
    expect_res("sticky_rup", 32'h0000_0002, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream of 1, 2, 4, 8 with a 3-cycle stall
    adv_i     = 1'b1;
    f2i_rdy_i = 1'b1;
    set_op(1'b0, 24'h800000, 5'd23, 4'd0, 1'b0, 1'b0, RM_ZERO);
    tick();
    set_op(1'b0, 24'h800000, 5'd22, 4'd0, 1'b0, 1'b0, RM_ZERO);
    tick();
    check("strm0.rdy", {31'd0, f2i_rnd_rdy_o}, 32'd1);
    check("strm0.int", f2i_int32_o, 32'd1);
    adv_i = 1'b0;
    set_op(1'b0, 24'h800000, 5'd21, 4'd0, 1'b0, 1'b0, RM_ZERO);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d.rdy", i), {31'd0, f2i_rnd_rdy_o}, 32'd1);
      check($sformatf("stall%0d.int", i), f2i_int32_o, 32'd1);
    end
    adv_i = 1'b1;
    tick();
    check("strm1.int", f2i_int32_o, 32'd2);
    set_op(1'b0, 24'h800000, 5'd20, 4'd0, 1'b0, 1'b0, RM_ZERO);
    tick();
    check("strm2.int", f2i_int32_o, 32'd4);
    f2i_rdy_i = 1'b0;
    tick();
    check("strm3.rdy", {31'd0, f2i_rnd_rdy_o}, 32'd1);
    check("strm3.int", f2i_int32_o, 32'd8);
    tick();
    check("strm_end.rdy", {31'd0, f2i_rnd_rdy_o}, 32'd0);

    // Flush with two operands in flight, with adv_i low
    f2i_rdy_i = 1'b1;
    set_op(1'b0, 24'hC00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_ZERO);
    tick();
    tick();
    check("pre_flush.rdy", {31'd0, f2i_rnd_rdy_o}, 32'd1);
    f2i_rdy_i = 1'b0;
    adv_i     = 1'b0;
    flush_i   = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush.rdy", {31'd0, f2i_rnd_rdy_o}, 32'd0);
    adv_i = 1'b1;
    tick();
    check("flush_a.rdy", {31'd0, f2i_rnd_rdy_o}, 32'd0);
    run_op(1'b0, 24'hA00000, 5'd22, 4'd0, 1'b0, 1'b0, RM_PLUSINF);
    expect_res("post_flush", 32'h0000_0003, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-stream
    f2i_rdy_i = 1'b1;
    set_op(1'b0, 24'hC00000, 5'd0, 4'd0, 1'b1, 1'b1, RM_NEAREST);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst.rdy",  {31'd0, f2i_rnd_rdy_o}, 32'd0);
    check("rst.int",  f2i_int32_o, 32'd0);
    check("rst.inv",  {31'd0, f2i_inv_o}, 32'd0);
    check("rst.snan", {31'd0, f2i_snan_o}, 32'd0);
    check("rst.ix",   {31'd0, f2i_ix_o}, 32'd0);
    f2i_rdy_i = 1'b0;
    tick();
    rst_n = 1'b1;
    set_op(1'b1, 24'hC00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_NEAREST);
    f2i_rdy_i = 1'b1;
    tick();
    f2i_rdy_i = 1'b0;
    check("post_rst1.rdy", {31'd0, f2i_rnd_rdy_o}, 32'd0);
    tick();
    expect_res("post_rst2", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
